fifo_ahb_master: RTL and testbench

//  Read-side consumer of a sync FIFO carrying 36-bit command entries; pops entries and

---
 rtl/ahblite_pkg.sv | 24 ++
 rtl/fifo_ahb_cmd_dec.sv | 24 ++
 rtl/fifo_ahb_master.sv | 181 ++++++++++++++++++
 tb/tb_fifo_ahb_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_pkg.sv
// rtl/ahblite_pkg.sv - AHB-Lite codes, command opcodes and entry layout for fifo_ahb_master
package ahblite_pkg;

  localparam int DATA_W = 36;
  localparam int OP_MSB = 35;
  localparam int OP_LSB = 32;
  localparam int PL_MSB = 31;
  localparam int PL_LSB = 0;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_WR  = 4'h2;
  localparam logic [3:0] OP_RD  = 4'h3;

  typedef enum logic [1:0] {CLS_NOP, CLS_LDA, CLS_WR, CLS_RD} op_class_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} ahbm_state_e;

endpackage

// File: rtl/fifo_ahb_cmd_dec.sv
// rtl/fifo_ahb_cmd_dec.sv - combinational split of a FIFO entry into op class and payload
module fifo_ahb_cmd_dec
  import ahblite_pkg::*;
(
  input  logic [DATA_W-1:0] entry_i,
  output op_class_e         op_cls_o,
  output logic [31:0]       payload_o
);

  logic [3:0] op;

  always_comb begin
    op        = entry_i[OP_MSB:OP_LSB];
    payload_o = entry_i[PL_MSB:PL_LSB];
    op_cls_o  = CLS_NOP;
    case (op)
      OP_LDA:  op_cls_o = CLS_LDA;
      OP_WR:   op_cls_o = CLS_WR;
      OP_RD:   op_cls_o = CLS_RD;
      default: op_cls_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/fifo_ahb_master.sv
// rtl/fifo_ahb_master.sv - pops command FIFO entries and issues single AHB-Lite transfers
// AHBM_ERR_STOP_EN: an ERROR response halts popping until err_clr_i.
module fifo_ahb_master
  import ahblite_pkg::*;
#(
  parameter int ADDR_INC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rempty_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              rfifo_o,
  output logic [31:0]       haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [31:0]       hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [31:0]       hrdata_i,
  output logic              rd_valid_o,
  output logic [31:0]       rd_data_o,
  input  logic              rd_ready_i,
  output logic              err_o,
  input  logic              err_clr_i
);

  ahbm_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] pl_q, pl_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        pop;
  logic        halt;
  op_class_e   cls;
  logic [31:0] payload;

  fifo_ahb_cmd_dec u_dec (
    .entry_i   (rdata_i),
    .op_cls_o  (cls),
    .payload_o (payload)
  );

`ifdef AHBM_ERR_STOP_EN
  logic halt_q, halt_d;

  // A new error wins over a simultaneous clear, matching err_o.
  always_comb begin
    halt_d = err_set | (halt_q & ~err_clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    pl_d       = pl_q;
    hwdata_d   = hwdata_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    err_set    = 1'b0;
    pop        = 1'b0;

    if (rd_valid_q && rd_ready_i) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rempty_i && !halt) begin
          case (cls)
            CLS_LDA: begin
              pop    = 1'b1;
              addr_d = {payload[31:2], 2'b00};
            end
            CLS_WR: begin
              wr_d    = 1'b1;
              pl_d    = payload;
              state_d = ST_ADDR;
            end
            CLS_RD: begin
              // Only one unread result can be held, so a new read waits for the consumer.
              if (!rd_valid_q) begin
                wr_d    = 1'b0;
                pl_d    = payload;
                state_d = ST_ADDR;
              end
            end
            default: pop = 1'b1;
          endcase
        end
      end
      ST_ADDR: begin
        if (hready_i) begin
          pop     = 1'b1;
          state_d = ST_DATA;
          if (wr_q) begin
            hwdata_d = pl_q;
          end
        end
      end
      ST_DATA: begin
        if (hresp_i == HRESP_ERROR) begin
          if (hready_i) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (hready_i) begin
          if (!wr_q) begin
            rd_data_d  = hrdata_i;
            rd_valid_d = 1'b1;
          end
          addr_d  = addr_q + 32'(ADDR_INC);
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (hready_i) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      pl_q       <= '0;
      hwdata_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      pl_q       <= pl_d;
      hwdata_q   <= hwdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  assign rfifo_o    = pop & ~rst;
  assign htrans_o   = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o    = addr_q;
  assign hwrite_o   = (state_q == ST_ADDR) & wr_q;
  assign hsize_o    = HSIZE_WORD;
  assign hburst_o   = HBURST_SINGLE;
  assign hwdata_o   = hwdata_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fifo_ahb_master.sv
// tb/tb_fifo_ahb_master.sv - directed scoreboard bench for fifo_ahb_master
module tb_fifo_ahb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        rempty_i;
  logic [35:0] rdata_i;
  logic        rfifo_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic        hresp_i;
  logic [31:0] hrdata_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        rd_ready_i;
  logic        err_o;
  logic        err_clr_i;

  fifo_ahb_master dut (
    .clk        (clk),
    .rst        (rst),
    .rempty_i   (rempty_i),
    .rdata_i    (rdata_i),
    .rfifo_o    (rfifo_o),
    .haddr_o    (haddr_o),
    .htrans_o   (htrans_o),
    .hwrite_o   (hwrite_o),
    .hsize_o    (hsize_o),
    .hburst_o   (hburst_o),
    .hwdata_o   (hwdata_o),
    .hready_i   (hready_i),
    .hresp_i    (hresp_i),
    .hrdata_i   (hrdata_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .rd_ready_i (rd_ready_i),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef enum int {S_IDLE, S_APH, S_DPH, S_E1} sl_e;

  bus_t        exp_bus[$];
  logic [31:0] exp_rd[$];
  logic [31:0] rd_resp_q[$];
  logic [35:0] fifo[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   err_hi = 0;
  int   ws = 0;
  int   aws = 0;
  int   dcnt = 0;
  int   acnt = 0;
  int   p0;
  int   e0;
  int   k;
  logic err_next = 1'b0;
  logic cur_wr, cur_err;
  logic [31:0] cur_wd;
  logic fifo_p;
  bus_t cur;
  sl_e  sl = S_IDLE;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    rempty_i = (fifo.size() == 0);
    rdata_i  = rempty_i ? 36'h0 : fifo[0];
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] pl);
    fifo.push_back({op, pl});
    upd_fifo();
  endtask

  task automatic exp_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_bus.push_back({wr, a, d});
  endtask

  task automatic exp_read(input logic [31:0] v);
    rd_resp_q.push_back(v);
    exp_rd.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (i < 300 && !(fifo.size() == 0 && exp_bus.size() == 0 && exp_rd.size() == 0 &&
                        sl == S_IDLE && htrans_o == 2'b00)) begin
      step(1);
      i++;
    end
    chk(tag, i < 300, 1);
    step(2);
  endtask

  // FIFO model: pop decided at the edge, applied just after it
  always @(posedge clk) begin
    fifo_p = rfifo_o;
    #1;
    if (fifo_p) begin
      chk("pop_nonempty", fifo.size() != 0, 1);
      if (fifo.size() != 0) begin
        void'(fifo.pop_front());
        n_pop++;
      end
    end
    upd_fifo();
  end

  // AHB slave model; decides HREADY/HRESP for the coming edge
  always @(negedge clk) begin
    if (rst) begin
      sl       = S_IDLE;
      hready_i = 1'b1;
      hresp_i  = 1'b0;
    end else begin
      case (sl)
        S_IDLE: begin
          hready_i = 1'b1;
          hresp_i  = 1'b0;
          if (htrans_o == 2'b10) begin
            if (exp_bus.size() == 0) begin
              chk("bus_unexp", 1, 0);
              cur_wr = hwrite_o;
              cur_wd = hwdata_o;
            end else begin
              cur = exp_bus.pop_front();
              chk("haddr", haddr_o, cur.addr);
              chk("hwrite", hwrite_o, cur.wr);
              cur_wr = cur.wr;
              cur_wd = cur.wdata;
            end
            if (!hwrite_o) chk("rd_blocked", rd_valid_o, 0);
            cur_err  = err_next;
            err_next = 1'b0;
            dcnt     = ws;
            acnt     = aws;
            if (acnt > 0) begin
              hready_i = 1'b0;
              acnt--;
              sl = S_APH;
            end else begin
              sl = S_DPH;
            end
          end
        end
        S_APH: begin
          chk("hold_nopop", rfifo_o, 0);
          chk("hold_htrans", htrans_o, 2'b10);
          if (acnt > 0) begin
            acnt--;
          end else begin
            hready_i = 1'b1;
            sl = S_DPH;
          end
        end
        S_DPH: begin
          chk("dph_htrans", htrans_o, 2'b00);
          if (cur_err) begin
            hready_i = 1'b0;
            hresp_i  = 1'b1;
            sl = S_E1;
          end else if (dcnt > 0) begin
            hready_i = 1'b0;
            dcnt--;
          end else begin
            hready_i = 1'b1;
            if (cur_wr) begin
              chk("hwdata", hwdata_o, cur_wd);
            end else if (rd_resp_q.size() != 0) begin
              hrdata_i = rd_resp_q.pop_front();
            end
            sl = S_IDLE;
          end
        end
        S_E1: begin
          chk("err_htrans", htrans_o, 2'b00);
          hready_i = 1'b1;
          hresp_i  = 1'b1;
          sl = S_IDLE;
        end
        default: sl = S_IDLE;
      endcase
    end
  end

  // Read-result consumer and error-pulse counter
  always @(negedge clk) begin
    if (!rst) begin
      if (err_o) err_hi++;
      if (rd_valid_o) begin
        if (exp_rd.size() == 0) chk("rd_unexp", rd_valid_o, 0);
        else if (rd_ready_i) chk("rd_data", rd_data_o, exp_rd.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdata_i = '0; rempty_i = 1'b1; hready_i = 1'b1; hresp_i = 1'b0;
    hrdata_i = '0; rd_ready_i = 1'b1; err_clr_i = 1'b0;
    step(3);
    chk("rst_rfifo", rfifo_o, 0);
    chk("rst_htrans", htrans_o, 2'b00);
    chk("rst_haddr", haddr_o, 0);
    chk("rst_hwrite", hwrite_o, 0);
    chk("rst_hwdata", hwdata_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_err", err_o, 0);
    chk("hsize", hsize_o, 3'b010);
    chk("hburst", hburst_o, 3'b000);
    rst = 1'b0;
    step(1);

    // LDA + WR, one address wait state
    aws = 1;
    p0 = n_pop;
    push(4'h1, 32'h1000_0000);
    push(4'h2, 32'hDEAD_BEEF);
    exp_xfer(1'b1, 32'h1000_0000, 32'hDEAD_BEEF);
    drain("t1_drain");
    chk("t1_pops", n_pop - p0, 2);
    aws = 0;

    // RD with two wait states, then address advanced by 4
    ws = 2;
    push(4'h3, 32'h0);
    exp_xfer(1'b0, 32'h1000_0004, 32'h0);
    exp_read(32'h1234_5678);
    drain("t2_drain");
    chk("t2_rd_data", rd_data_o, 32'h1234_5678);
    chk("t2_rd_valid_dropped", rd_valid_o, 0);
    ws = 0;
    push(4'h2, 32'hCAFE_0001);
    exp_xfer(1'b1, 32'h1000_0008, 32'hCAFE_0001);
    drain("t2_next");

    // Back-to-back RDs with consumer stalled
    rd_ready_i = 1'b0;
    push(4'h3, 32'h0);
    push(4'h3, 32'h0);
    exp_xfer(1'b0, 32'h1000_000C, 32'h0);
    exp_xfer(1'b0, 32'h1000_0010, 32'h0);
    exp_read(32'hAAAA_0001);
    exp_read(32'hAAAA_0002);
    step(15);
    chk("t3_valid", rd_valid_o, 1);
    chk("t3_data", rd_data_o, 32'hAAAA_0001);
    chk("t3_fifo_held", fifo.size(), 1);
    chk("t3_not_issued", exp_bus.size(), 1);
    rd_ready_i = 1'b1;
    drain("t3_drain");

    // Address wrap; LDA clears low bits
    push(4'h1, 32'hFFFF_FFFE);
    push(4'h2, 32'h1111_1111);
    push(4'h2, 32'h2222_2222);
    exp_xfer(1'b1, 32'hFFFF_FFFC, 32'h1111_1111);
    exp_xfer(1'b1, 32'h0000_0000, 32'h2222_2222);
    drain("t4_drain");
    chk("t4_addr_after", haddr_o, 32'h0000_0004);

    // ERROR on WR; failed transfer leaves the address unchanged
    err_next = 1'b1;
    push(4'h2, 32'h3333_3333);
    push(4'h2, 32'h4444_4444);
    exp_xfer(1'b1, 32'h0000_0004, 32'h3333_3333);
    exp_xfer(1'b1, 32'h0000_0004, 32'h4444_4444);
    step(12);
`ifdef AHBM_ERR_STOP_EN
    chk("t5_halt_fifo", fifo.size(), 1);
    chk("t5_halt_err", err_o, 1);
    chk("t5_halt_no_issue", exp_bus.size(), 1);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    chk("t5_err_cleared", err_o, 0);
    drain("t5_drain");
`else
    drain("t5_drain");
    chk("t5_err", err_o, 1);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    chk("t5_err_cleared", err_o, 0);
`endif

    // Error set while clear held: err_o high for exactly one cycle
    err_clr_i = 1'b1;
    err_next = 1'b1;
    e0 = err_hi;
    push(4'h2, 32'h5555_5555);
    exp_xfer(1'b1, 32'h0000_0008, 32'h5555_5555);
    drain("t6_drain");
    step(2);
    err_clr_i = 1'b0;
    chk("t6_err_pulse", err_hi - e0, 1);
    chk("t6_err_low", err_o, 0);

    // Reset during RD data phase, then unknown op popped silently
    ws = 5;
    push(4'h3, 32'h0);
    exp_xfer(1'b0, 32'h0000_0008, 32'h0);
    rd_resp_q.push_back(32'hBAD0_BAD0);
    k = 0;
    while (sl != S_DPH && k < 50) begin
      step(1);
      k++;
    end
    chk("t7_reach_dph", sl == S_DPH, 1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    ws = 0;
    rd_resp_q.delete();
    chk("t7_htrans", htrans_o, 2'b00);
    chk("t7_haddr", haddr_o, 0);
    chk("t7_hwrite", hwrite_o, 0);
    chk("t7_hwdata", hwdata_o, 0);
    chk("t7_rd_valid", rd_valid_o, 0);
    chk("t7_rd_data", rd_data_o, 0);
    chk("t7_err", err_o, 0);
    chk("t7_rfifo", rfifo_o, 0);
    p0 = n_pop;
    push(4'hF, 32'h0000_1234);
    step(4);
    chk("t7_f_popped", fifo.size(), 0);
    chk("t7_f_pop_count", n_pop - p0, 1);
    chk("t7_f_no_bus", htrans_o, 2'b00);
    chk("t7_rd_valid_after", rd_valid_o, 0);
    push(4'h2, 32'h7777_0000);
    exp_xfer(1'b1, 32'h0000_0000, 32'h7777_0000);
    drain("t7_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
